// File: rtl/elevator_pkg.sv
// ----------------------------------------------------------------------------
// elevator_pkg
// Definitions shared by the request encoder and the management stage that
// reads its output.
//   CODE_IDLE / CODE_EMERG : reserved codes on the request bus
//   NUM_FLOORS             : number of floor buttons (floors 1..NUM_FLOORS)
//   floor_code_t           : 4-bit code, floor i is encoded as i
//   mode_t                 : encoder operating mode (normal / emergency)
//   lowest_floor_code()    : code of the lowest-numbered set bit in a mask
//   code_to_mask()         : one-hot floor mask for a floor code
// ----------------------------------------------------------------------------
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 9;

  typedef logic [3:0] floor_code_t;

  localparam floor_code_t CODE_IDLE  = 4'b0000;
  localparam floor_code_t CODE_EMERG = 4'b1011;

  typedef enum logic {
    MODE_NORMAL,
    MODE_EMERG
  } mode_t;

  // Bit i of the mask stands for floor i+1. Returns CODE_IDLE for an empty mask.
  function automatic floor_code_t lowest_floor_code(input logic [NUM_FLOORS-1:0] mask);
    floor_code_t code;
    code = CODE_IDLE;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (mask[i]) code = floor_code_t'(i + 1);
    end
    return code;
  endfunction

  // Codes outside 1..NUM_FLOORS map to an empty mask.
  function automatic logic [NUM_FLOORS-1:0] code_to_mask(input floor_code_t code);
    logic [NUM_FLOORS-1:0] mask;
    mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (code == floor_code_t'(i + 1)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/request_encoder_if.sv
// ----------------------------------------------------------------------------
// request_encoder_if
// Button inputs and request-bus handshake of the request encoder.
//   BTN        : raw floor buttons, bit i-1 = floor i, high = pressed
//   EMERG      : raw emergency button, high = pressed
//   REQ_ACK    : consumer pop strobe
//   BCD_input  : code of the request at the head of the queue
//   REQ_VALID  : BCD_input carries a non-idle code
//   QUEUE_FULL : request queue holds its maximum number of entries
// Modports: master = the encoder, slave = buttons plus consuming stage.
// ----------------------------------------------------------------------------
interface request_encoder_if;
  import elevator_pkg::*;

  logic [NUM_FLOORS-1:0] BTN;
  logic                  EMERG;
  logic                  REQ_ACK;
  floor_code_t           BCD_input;
  logic                  REQ_VALID;
  logic                  QUEUE_FULL;

  modport master (
    input  BTN, EMERG, REQ_ACK,
    output BCD_input, REQ_VALID, QUEUE_FULL
  );

  modport slave (
    output BTN, EMERG, REQ_ACK,
    input  BCD_input, REQ_VALID, QUEUE_FULL
  );
endinterface

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
// Two-flop synchroniser followed by a stability counter. The debounced level
// flips only after DEBOUNCE_CYCLES consecutive synchronised samples that
// differ from it; a sample equal to the current level restarts the count.
// rise_o is a one-cycle registered pulse in the cycle after a 0->1 acceptance.
//   CLK    : clock, rising edge
//   RST    : synchronous active-high reset
//   btn_i  : asynchronous raw button level
//   rise_o : one-cycle pulse per accepted press
// ----------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic btn_i,
  output logic rise_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // values from before the edge, which makes the two-flop chain a real chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/request_encoder.sv
// ----------------------------------------------------------------------------
// request_encoder
// Turns debounced floor presses into a queue of floor codes for the
// management stage. A press marks the floor pending; each cycle the lowest
// pending floor moves into the FIFO if there is room. A floor already pending
// or queued ignores further presses. An emergency press flushes everything
// and presents CODE_EMERG until acknowledged.
//   CLK : clock, rising edge
//   RST : synchronous active-high reset
//   bus : request_encoder_if.master (buttons, ACK, code/valid/full outputs)
// ----------------------------------------------------------------------------
module request_encoder
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned QUEUE_DEPTH     = 4   // power of two, >= 2
) (
  input logic               CLK,
  input logic               RST,
  request_encoder_if.master bus
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [NUM_FLOORS-1:0] btn_rise;
  logic                  emerg_rise;

  mode_t                 mode_q, mode_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_FLOORS-1:0] queued_q, queued_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  floor_code_t           fifo_mem [QUEUE_DEPTH];

  logic [NUM_FLOORS-1:0] candidates;
  logic [NUM_FLOORS-1:0] grant_mask;
  logic [NUM_FLOORS-1:0] pop_mask;
  floor_code_t           push_code;
  floor_code_t           head_code;
  logic                  do_push, do_pop;
  logic                  fifo_empty, fifo_full;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .CLK    (CLK),
      .RST    (RST),
      .btn_i  (bus.BTN[i]),
      .rise_o (btn_rise[i])
    );
  end

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_emerg (
    .CLK    (CLK),
    .RST    (RST),
    .btn_i  (bus.EMERG),
    .rise_o (emerg_rise)
  );

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(QUEUE_DEPTH));
  assign head_code  = fifo_mem[rd_ptr_q];

  always_comb begin
    mode_d     = mode_q;
    pending_d  = pending_q;
    queued_d   = queued_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    candidates = '0;
    grant_mask = '0;
    pop_mask   = '0;
    push_code  = CODE_IDLE;
    do_push    = 1'b0;
    do_pop     = 1'b0;

    if (emerg_rise) begin
      // Emergency beats any coincident press or ACK: flush and latch.
      mode_d    = MODE_EMERG;
      pending_d = '0;
      queued_d  = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end else if (mode_q == MODE_EMERG) begin
      // Queue is empty and presses are dropped while latched.
      if (bus.REQ_ACK) mode_d = MODE_NORMAL;
    end else begin
      // New presses join the pending set in the same cycle they are accepted,
      // so a press can be granted without first landing in pending_q.
      candidates = pending_q | (btn_rise & ~queued_q);
      do_pop     = bus.REQ_ACK && !fifo_empty;
      if (!fifo_full && (candidates != '0)) begin
        do_push   = 1'b1;
        push_code = lowest_floor_code(candidates);
      end
      grant_mask = code_to_mask(push_code);
      if (do_pop) pop_mask = code_to_mask(head_code);

      pending_d = candidates & ~grant_mask;
      queued_d  = (queued_q & ~pop_mask) | grant_mask;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q    <= MODE_NORMAL;
      pending_q <= '0;
      queued_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      pending_q <= pending_d;
      queued_q  <= queued_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count decide which
  // entries are valid, and the output mux never shows an unwritten slot.
  always_ff @(posedge CLK) begin
    if (do_push) fifo_mem[wr_ptr_q] <= push_code;
  end

  assign bus.BCD_input  = (mode_q == MODE_EMERG) ? CODE_EMERG
                        : (fifo_empty ? CODE_IDLE : head_code);
  assign bus.REQ_VALID  = (mode_q == MODE_EMERG) || !fifo_empty;
  assign bus.QUEUE_FULL = fifo_full;

endmodule

// File: doc/request_encoder.md
REQUEST_ENCODER -- requirements
Module: request_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed to accept a press or release.
REQ-002 Parameter QUEUE_DEPTH, default 4: request FIFO entries, power of two.
REQ-003 CLK  input  1: single clock; all logic on its rising edge.
REQ-004 RST  input  1: reset, synchronous, active-high.
REQ-005 BTN  input  9: asynchronous floor buttons; bit i-1 = floor i (1..9), high = pressed.
REQ-006 EMERG  input  1: asynchronous emergency button, high = pressed.
REQ-007 REQ_ACK  input  1: consumer pop strobe, one cycle per accepted code.
REQ-008 BCD_input  output  4: code to the management stage: 4'b0001..4'b1001 floor, 4'b1011 emergency, 4'b0000 idle.
REQ-009 REQ_VALID  output  1: high when BCD_input carries a non-idle code.
REQ-010 QUEUE_FULL  output  1: high when the FIFO holds QUEUE_DEPTH entries.

Function
REQ-011 Each BTN bit and EMERG SHALL pass through a 2-flop synchroniser before any other use.
REQ-012 Debounce: a synchronised level SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal samples; any mismatch restarts the count at 0.
REQ-013 A debounced 0->1 transition of floor i SHALL set pending[i]; a held button SHALL generate exactly one request.
REQ-014 A press of floor i SHALL be ignored if pending[i] or queued[i] is already set (duplicate suppression).
REQ-015 Arbiter: each cycle, if the FIFO is not full, the lowest-numbered set pending bit SHALL be cleared and its code pushed; at most one push per cycle.
REQ-016 FIFO full: pending bits SHALL remain set, with no request lost, and drain in ascending floor order once space frees.
REQ-017 BCD_input SHALL equal the FIFO head code while non-empty, else 4'b0000; REQ_VALID = FIFO non-empty or emergency latched.
REQ-018 REQ_ACK with REQ_VALID high SHALL pop the head, clear its queued bit, and expose the next entry on the following cycle; REQ_ACK while REQ_VALID is low SHALL be ignored.
REQ-019 Push and pop in the same cycle SHALL both occur; occupancy is unchanged; read and write pointers wrap modulo QUEUE_DEPTH.
REQ-020 Latency: with empty FIFO and idle arbiter, REQ_VALID SHALL rise after the (DEBOUNCE_CYCLES+3)th rising edge following BTN going high.
REQ-021 Debounced EMERG rise SHALL flush the FIFO, the pending mask and the queued mask, and latch the emergency state.
REQ-022 While emergency is latched, BCD_input SHALL be 4'b1011 and REQ_VALID high; floor presses SHALL be ignored; REQ_ACK SHALL clear the latch.
REQ-023 EMERG rise coincident with a floor press or REQ_ACK: emergency wins; the floor press is dropped and the ACK is applied to the emergency code only after the latch is visible.
REQ-024 Codes 4'b1010 and 4'b1100..4'b1111 SHALL never be driven.

Reset
REQ-025 RST high at a rising edge SHALL clear synchronisers, debounce counters, debounced levels, pending and queued masks, FIFO pointers and the emergency latch.
REQ-026 During and after reset: BCD_input = 4'b0000, REQ_VALID = 0, QUEUE_FULL = 0.
REQ-027 A button held through reset release SHALL produce one request after the full debounce (REQ-020); reset mid-operation SHALL discard all queued requests.

Structure
REQ-028 Shared package elevator_pkg SHALL hold CODE_IDLE = 4'b0000, CODE_EMERG = 4'b1011, NUM_FLOORS = 9 and the floor-code type; the management stage SHALL use the same package.
REQ-029 Sub-module button_debouncer (synchroniser, counter and rise pulse) SHALL be instantiated 10 times: 9 floors plus EMERG.

Verification (DEBOUNCE_CYCLES=4, QUEUE_DEPTH=4)
REQ-030 Reset then BTN[2] held for 10 cycles -> BCD_input = 4'b0011 and REQ_VALID high after edge 7; one entry only; ACK -> 4'b0000.
REQ-031 BTN[0] glitch high for 3 cycles -> no request; REQ_VALID stays 0.
REQ-032 BTN[4], BTN[1] and BTN[7] pressed in the same cycle -> codes 0010, 0101, 1000 pushed on consecutive cycles; ACKs pop them in that order.
REQ-033 Five distinct floors pressed with no ACK -> QUEUE_FULL = 1 after 4 pushes; the fifth stays pending and appears after one ACK; pressing floor 3 twice while it is queued -> a single entry.
REQ-034 Three floors queued, then EMERG pressed -> BCD_input = 4'b1011 and queue empty; ACK -> REQ_VALID = 0 and BCD_input = 4'b0000.
REQ-035 RST asserted with 2 entries queued and 1 pending -> next cycle all outputs are at their reset values; no stale code reappears.
